// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//
// Scans a 4x4 active-low matrix keypad one row at a time. The block
// debounces at frame granularity and reports each newly accepted key.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   col_n[3:0] : column sense lines, active-low, asynchronous to clk
//   row_n[0:3] : row strobes, active-low, exactly one bit low at a time
//   key_code   : last accepted key, row*4 + col
//   key_valid  : one-cycle pulse in the cycle after a frame accepts a press
//   key_held   : high from acceptance until the release is debounced
//   fsm_state  : debug view of the debounce FSM (IDLE/DEBOUNCE/PRESSED/RELEASE)
//
// Output protocol: key_valid is a single-cycle strobe with no back-pressure.
// key_code is valid in the key_valid cycle and holds until the next
// acceptance. key_valid never repeats until key_held has dropped.
//
// Timing: each row is strobed for SCAN_DIV cycles. The synchronized columns
// are sampled only on the last cycle of the dwell. This leaves the 2-flop
// synchronizer and the keypad wiring time to settle after the strobe moves,
// which is why SCAN_DIV must be at least 4. Four row samples form one frame.
// The FSM advances only on the row-3 sample.

module keypad_scan_encoder #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [0:3] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] fsm_state
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  // ---------------------------------------------------------------------
  // Row scan timing
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       r;
  logic             dwell_last;
  logic             frame_end;

  assign dwell_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end  = dwell_last && (r == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      r       <= 2'd0;
    end else if (dwell_last) begin
      div_cnt <= '0;
      r       <= r + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    row_n    = 4'b1111;
    row_n[r] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------
  logic [3:0] col_s1;
  logic [3:0] col_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'b0000;
      col_s2 <= 4'b0000;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-frame priority encode: the lowest row wins, then the lowest column.
  // ---------------------------------------------------------------------
  logic       row_hit;
  logic [1:0] row_col;

  assign row_hit = ~&col_s2;

  always_comb begin
    row_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s2[i]) row_col = 2'(i);
    end
  end

  logic       found_acc;
  logic [3:0] code_acc;

  // The row-0 sample restarts the accumulator. A later row contributes only
  // when no earlier row in the same frame has already reported a key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_acc <= 1'b0;
      code_acc  <= 4'd0;
    end else if (dwell_last && ((r == 2'd0) || !found_acc)) begin
      found_acc <= row_hit;
      code_acc  <= {r, row_col};
    end
  end

  // The frame result combines rows 0..2 (accumulated) with the live row-3
  // sample. It is meaningful only when frame_end is high.
  logic       frame_found;
  logic [3:0] frame_code;

  assign frame_found = found_acc | row_hit;
  assign frame_code  = found_acc ? code_acc : {r, row_col};

  // ---------------------------------------------------------------------
  // Debounce FSM, evaluated at frame end only
  // ---------------------------------------------------------------------
  logic [1:0]       state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] rel_cnt;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'd0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_found) begin
              cand <= frame_code;
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= PRESSED;
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match_cnt <= '0;
              end else begin
                state     <= DEBOUNCE;
                match_cnt <= CNT_W'(1);
              end
            end
          end

          DEBOUNCE: begin
            if (!frame_found) begin
              state     <= IDLE;
              match_cnt <= '0;
            end else if (frame_code != cand) begin
              cand      <= frame_code;
              match_cnt <= CNT_W'(1);
            end else if (match_cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              state     <= PRESSED;
              key_code  <= cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + CNT_W'(1);
            end
          end

          PRESSED: begin
            // Any found frame keeps the key held; a change of key while held
            // is not reported until a full release has been seen.
            if (!frame_found) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state    <= IDLE;
                key_held <= 1'b0;
                rel_cnt  <= '0;
              end else begin
                state   <= RELEASE;
                rel_cnt <= CNT_W'(1);
              end
            end
          end

          RELEASE: begin
            if (frame_found) begin
              state   <= PRESSED;
              rel_cnt <= '0;
            end else if (rel_cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              state    <= IDLE;
              key_held <= 1'b0;
              rel_cnt  <= '0;
            end else begin
              rel_cnt <= rel_cnt + CNT_W'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan_encoder.md
KEYPAD_SCAN_ENCODER -- requirements
Module: keypad_scan_encoder

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each row strobe stays active. Legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 2: consecutive matching scan frames needed to accept a press or a release. Legal values are 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port col_n, input, [3:0]: keypad column sense lines, active-low, asynchronous to clk.
REQ-006 SHALL have port row_n, output, [0:3]: keypad row strobes, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code, output, [3:0]: encoded key index, equal to row*4 + col.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse marking a newly accepted press.
REQ-009 SHALL have port key_held, output, 1 bit: level output, high while an accepted key has not yet been released.

Function
REQ-010 SHALL keep a 2-bit row index r and drive row_n[r]=0, all other row_n bits 1 (r=0 gives row_n=0111).
REQ-011 SHALL hold each row for exactly SCAN_DIV cycles, then advance r by 1, wrapping from 3 to 0.
REQ-012 SHALL pass col_n through a 2-flop synchronizer before any use.
REQ-013 SHALL sample the synchronized columns on the last cycle of each row's dwell only.
REQ-014 SHALL define one frame as four row samples (r=0..3); the frame ends at the row-3 sample.
REQ-015 SHALL compute a per-frame result: found/none, plus a code from the lowest r, then lowest column, with a low sample; higher-index simultaneous keys are ignored.
REQ-016 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated only at frame end.
REQ-017 IDLE: a found frame SHALL load the candidate code, set the match count to 1, and go to DEBOUNCE; a none frame SHALL stay in IDLE.
REQ-018 DEBOUNCE: a frame with the same code SHALL increment the match count.
REQ-019 DEBOUNCE: when the count reaches DEBOUNCE_FRAMES, the FSM SHALL go to PRESSED and drive key_code=candidate, key_valid=1 for one cycle, and key_held=1.
REQ-020 DEBOUNCE: a different code SHALL reload the candidate with count 1; a none frame SHALL return to IDLE without any key_valid.
REQ-021 With DEBOUNCE_FRAMES=1, the first found frame SHALL go directly IDLE->PRESSED with key_valid asserted.
REQ-022 PRESSED: found frames of any code SHALL keep the state, and key_code SHALL not change; a none frame SHALL set the release count to 1 and go to RELEASE.
REQ-023 RELEASE: none frames SHALL increment the release count; at DEBOUNCE_FRAMES the FSM SHALL go to IDLE and drive key_held=0.
REQ-024 RELEASE: any found frame SHALL return to PRESSED with no key_valid.
REQ-025 key_valid SHALL be asserted in the cycle immediately after the accepting frame-end sample. It SHALL never be high for 2 consecutive cycles and SHALL never fire twice without an intervening release.
REQ-026 key_code SHALL hold its last accepted value until the next acceptance.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: r=0, row_n=0111, key_code=0, key_valid=0, key_held=0, state=IDLE, all counters and synchronizer flops 0.
REQ-028 Reset asserted mid-debounce or mid-press SHALL discard the candidate and SHALL produce no key_valid after deassertion until a full new debounce completes.
REQ-029 After rst_n rises, the first row advance SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2; one frame = 16 cycles)
REQ-030 Reset release, col_n=1111 -> row_n is 0111, 1011, 1101, 1110 at 4-cycle steps, back to 0111 at cycle 16; key_valid stays 0.
REQ-031 Key at row 2, col 1 held (col_n[1]=0 only while row_n[2]=0) -> exactly one key_valid pulse with key_code=9 after the second full frame, key_held=1.
REQ-032 Same key for one frame only, then released -> no key_valid, key_held stays 0, FSM returns to IDLE.
REQ-033 Keys (r1,c3) and (r2,c0) held together -> key_code=7, with a single pulse.
REQ-034 Release after REQ-031 -> key_held falls after 2 empty frames; re-press of key 9 -> a second key_valid; a one-frame release glitch -> no second pulse.
REQ-035 rst_n pulsed low while key_held=1 -> key_held=0 and row_n=0111 immediately; a held key re-accepts only after 2 frames post-reset.
